// File: rtl/pe_array.sv
// 3x3 cross-correlation column engine: a sliding two-column history per input row
// plus the incoming column feed one MAC tree per output row; results are registered.
module pe_array #(
  parameter int INPUTS_MAC = 6,
  parameter int COLS_MAC   = 4   // must be INPUTS_MAC-2: each output row needs rows r..r+2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_kernel,
  input  logic [7:0] inputs_mac  [0:INPUTS_MAC-1],
  input  logic [7:0] weights     [0:8],
  output logic [7:0] outputs_mac [0:COLS_MAC-1]
);

  // Kernel, flattened row-major: w_q[3*k+j] is kernel row k, column j.
  logic [7:0] w_q [0:8];

  // Column history per input row. Only the two most recent columns feed the MAC
  // (the third tap is the live input), so the oldest window slot is never stored.
  logic [7:0] x_mid [0:INPUTS_MAC-1];
  logic [7:0] x_new [0:INPUTS_MAC-1];

  logic [COLS_MAC-1:0][7:0] sum_lo;

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    return {8'd0, a} * {8'd0, b};
  endfunction

  for (genvar r = 0; r < COLS_MAC; r++) begin : g_mac
    // 20 bits holds 9 * 255 * 255 without overflow; only the low byte is kept.
    logic [19:0] acc;

    always_comb begin
      acc = '0;
      for (int k = 0; k < 3; k++) begin
        acc = acc + 20'(mul8(w_q[3*k],     x_mid[r+k]));
        acc = acc + 20'(mul8(w_q[3*k + 1], x_new[r+k]));
        acc = acc + 20'(mul8(w_q[3*k + 2], inputs_mac[r+k]));
      end
    end

    assign sum_lo[r] = 8'(acc);
  end

  // The MAC reads the pre-edge kernel, so a load takes effect one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) w_q[n] <= '0;
      for (int i = 0; i < INPUTS_MAC; i++) begin
        x_mid[i] <= '0;
        x_new[i] <= '0;
      end
      for (int r = 0; r < COLS_MAC; r++) outputs_mac[r] <= '0;
    end else begin
      if (write_kernel) begin
        for (int n = 0; n < 9; n++) w_q[n] <= weights[n];
      end
      for (int i = 0; i < INPUTS_MAC; i++) begin
        x_mid[i] <= x_new[i];
        x_new[i] <= inputs_mac[i];
      end
      for (int r = 0; r < COLS_MAC; r++) outputs_mac[r] <= sum_lo[r];
    end
  end

endmodule

// File: tb/tb_pe_array.sv
// Randomized and directed stimulus for pe_array, checked against a column-history
// reference model through an expected-output queue.
module tb_pe_array;
  localparam int N = 6;
  localparam int C = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       write_kernel;
  logic [7:0] inputs_mac  [0:N-1];
  logic [7:0] weights     [0:8];
  logic [7:0] outputs_mac [0:C-1];

  always #5 clk = ~clk;

  pe_array #(.INPUTS_MAC(N), .COLS_MAC(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_kernel (write_kernel),
    .inputs_mac   (inputs_mac),
    .weights      (weights),
    .outputs_mac  (outputs_mac)
  );

  // ---------------- reference model state ----------------
  logic [C*8-1:0] exp_q  [$];
  logic [N*8-1:0] hist_q [$];   // columns applied since last reset, zero-filled
  int             kw [0:8];     // kernel in effect
  logic [7:0]     col_s [0:N-1];
  logic [7:0]     w_s   [0:8];
  int             checks = 0;
  int             passed = 0;

  // ---------------- driver ----------------
  task automatic tick(input bit r, input bit wk);
    logic [N*8-1:0] cur;
    logic [C*8-1:0] e;
    logic [N*8-1:0] col;
    int s, tap;
    @(negedge clk);
    rst = r;
    write_kernel = wk;
    for (int i = 0; i < N; i++) inputs_mac[i] = col_s[i];
    for (int n = 0; n < 9; n++) weights[n] = w_s[n];
    for (int i = 0; i < N; i++) cur[i*8 +: 8] = col_s[i];
    e = '0;
    if (r) begin
      hist_q.delete();
      hist_q.push_back('0);
      hist_q.push_back('0);
      for (int n = 0; n < 9; n++) kw[n] = 0;
    end else begin
      // Output row ro: sum of kernel(k,j) * input row ro+k at column age 2-j.
      for (int ro = 0; ro < C; ro++) begin
        s = 0;
        for (int k = 0; k < 3; k++) begin
          for (int j = 0; j < 3; j++) begin
            col = (j == 2) ? cur : hist_q[hist_q.size() - 2 + j];
            tap = int'(col[(ro+k)*8 +: 8]);
            s += kw[3*k + j] * tap;
          end
        end
        e[ro*8 +: 8] = 8'(s % 256);
      end
      hist_q.push_back(cur);
      if (hist_q.size() > 2) void'(hist_q.pop_front());
      if (wk) for (int n = 0; n < 9; n++) kw[n] = int'(w_s[n]);
    end
    exp_q.push_back(e);
  endtask

  task automatic set_col_all(input logic [7:0] v);
    for (int i = 0; i < N; i++) col_s[i] = v;
  endtask

  task automatic set_w_rows(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int k = 0; k < 3; k++) begin
      w_s[3*k] = a; w_s[3*k+1] = b; w_s[3*k+2] = c;
    end
  endtask

  task automatic set_random;
    for (int i = 0; i < N; i++) col_s[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 9; n++) w_s[n] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic [C*8-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int r = 0; r < C; r++) begin
          checks++;
          if (outputs_mac[r] === e[r*8 +: 8]) passed++;
          else $display("FAIL out_row%0d at %0t: got %0d expected %0d",
                        r, $time, outputs_mac[r], e[r*8 +: 8]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst = 1'b1; write_kernel = 1'b0;
    for (int i = 0; i < N; i++) inputs_mac[i] = '0;
    for (int n = 0; n < 9; n++) weights[n] = '0;
    hist_q.push_back('0);
    hist_q.push_back('0);
    for (int n = 0; n < 9; n++) kw[n] = 0;

    // Reset with a load request and junk data: reset must win.
    set_random();
    tick(1, 1);
    tick(1, 1);

    // Rows {1,2,3}, columns 0,1,2,3,0 -> 24, 42, 24, 9, 0.
    set_col_all(8'd0);
    set_w_rows(8'd1, 8'd2, 8'd3);
    tick(0, 1);
    for (int t = 0; t < 8; t++) begin
      set_col_all((t >= 1 && t <= 3) ? 8'(t) : 8'd0);
      tick(0, 0);
    end

    // All 255 -> 9 on every row.
    set_w_rows(8'd255, 8'd255, 8'd255);
    set_col_all(8'd255);
    tick(0, 1);
    repeat (4) tick(0, 0);

    // Centre tap only, inputs_mac[i] = i+1 -> row r reads r+2.
    for (int n = 0; n < 9; n++) w_s[n] = '0;
    w_s[4] = 8'd1;
    for (int i = 0; i < N; i++) col_s[i] = 8'(i + 1);
    tick(0, 1);
    repeat (4) tick(0, 0);

    // Kernel swap while streaming constant data.
    set_w_rows(8'd2, 8'd0, 8'd1);
    tick(0, 1);
    repeat (3) tick(0, 0);

    // Mid-stream reset: kernel lost, outputs stay 0 until reload.
    tick(1, 0);
    set_col_all(8'd7);
    repeat (4) tick(0, 0);
    set_w_rows(8'd1, 8'd1, 8'd1);
    tick(0, 1);
    repeat (3) tick(0, 0);

    // Oldest tap only with a ramp: output lags input by two columns.
    set_w_rows(8'd1, 8'd0, 8'd0);
    set_col_all(8'd0);
    tick(0, 1);
    for (int t = 1; t <= 6; t++) begin
      set_col_all(8'(t));
      tick(0, 0);
    end

    // Held write_kernel with changing weights.
    for (int t = 0; t < 6; t++) begin
      set_random();
      tick(0, 1);
    end

    // Random soak.
    for (int t = 0; t < 300; t++) begin
      set_random();
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expected outputs never checked, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pe_array.md
PE_ARRAY -- requirements
Module: pe_array

Interface
REQ-001 Parameter INPUTS_MAC, default 6: number of input rows streamed per cycle.
REQ-002 Parameter COLS_MAC, default 4: number of output rows; SHALL equal INPUTS_MAC-2.
REQ-003 Kernel size fixed at 3x3; not parameterized.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 write_kernel  input  1  when high at a rising edge, load weights into kernel registers.
REQ-007 inputs_mac  input  unpacked array [0:INPUTS_MAC-1] of 8-bit  one input column; element i is input row i.
REQ-008 weights  input  unpacked array [0:8] of 8-bit  3x3 kernel, row-major: weights[3*k+j] = kernel row k, column j.
REQ-009 outputs_mac  output  unpacked array [0:COLS_MAC-1] of 8-bit  registered output column; element r is output row r.

Function
REQ-010 Internal kernel register W[k][j] (9 x 8 bit) SHALL hold the last loaded weights; weights is ignored while write_kernel is low.
REQ-011 Per input row i, a 3-deep column window SHALL hold X[i][0] (oldest), X[i][1], X[i][2] (newest).
REQ-012 Each rising edge without rst: X[i][0]<=X[i][1], X[i][1]<=X[i][2], X[i][2]<=inputs_mac[i]; shifts every cycle, no enable.
REQ-013 Each rising edge without rst: outputs_mac[r] <= low 8 bits of sum over k,j in 0..2 of W[k][j]*V[r+k][j], where V[i] = {X[i][1], X[i][2], inputs_mac[i]} (j=0 oldest, j=2 = current input).
REQ-014 Latency: outputs_mac after edge n reflects the input columns presented at edges n-2, n-1, n; result visible one cycle after the third column is applied.
REQ-015 Arithmetic unsigned; products 16 bit; accumulation at least 20 bit, no overflow; output truncated modulo 256, no saturation.
REQ-016 Operation is cross-correlation (no kernel flip); each output row r uses input rows r, r+1, r+2.
REQ-017 write_kernel and compute at the same edge: the output computed at that edge SHALL use the old W; the new W applies from the next edge.
REQ-018 A kernel load SHALL NOT clear the column window or outputs.
REQ-019 write_kernel held high for several cycles: W reloads each edge from current weights.
REQ-020 No valid/handshake signals; outputs update every cycle, including while the window still holds fewer than 3 real columns.
REQ-021 Implementation: one MAC tree per output row (COLS_MAC instances); generate loops over INPUTS_MAC/COLS_MAC.

Reset
REQ-022 rst high at a rising edge: W, all X[i][j] and all outputs_mac SHALL clear to 0.
REQ-023 rst has priority over write_kernel and shifting; weights presented during reset are not loaded.
REQ-024 Reset mid-stream discards the window; after release, outputs follow REQ-013 with zero-filled history.

Verification
REQ-025 Reset, load weights all rows {1,2,3}, feed columns 0,1,2,3,0 (all rows equal) -> outputs_mac all rows = 24, 42, 24, 9, then 0, one cycle after each of columns 2,3,0,next-0,next-0.
REQ-026 Weights all 255, all inputs 255 for 3 cycles -> 9*65025 = 585225 mod 256 = 9 on every output.
REQ-027 Row separation: weights only W[1][1]=1, inputs_mac[i]=i+1 constant -> outputs_mac[r] = r+2 after window fills.
REQ-028 write_kernel pulse while streaming constant data: output at the load edge uses old kernel, next edge uses new kernel.
REQ-029 Assert rst mid-stream -> all outputs 0 next edge; kernel must be reloaded (outputs stay 0 until write_kernel).
REQ-030 Window order: weights row {1,0,0} only, feed ramp 1,2,3,4 -> outputs show the column two cycles older (oldest tap).
